// File: rtl/register_bank8.sv
// ---------------------------------------------------------------------------
// register_bank8
//   Eight-entry general-purpose register bank feeding the 8:1 bus mux.
//   R7 doubles as the program counter and can auto-increment. A sticky
//   "written" mask records which registers were explicitly written since
//   reset.
//
// Ports
//   Clock    in   1      rising-edge clock
//   Reset    in   1      synchronous, active-high; dominates all inputs
//   wr_en    in   1      write strobe
//   wr_addr  in   3      destination register index
//   wr_data  in   WIDTH  write data
//   pc_incr  in   1      increment R7 on this edge
//   R0..R7   out  WIDTH  registered contents, one port per register
//   written  out  8      bit i set once Ri has been written since reset
//   pc_wrap  out  1      one-cycle pulse when R7 wraps all-ones -> 0
//
// Interface timing: there is no valid/ready handshake. A write is accepted
// on every edge where wr_en is high and becomes visible on R0..R7 one cycle
// later; there is no write-through bypass.
// ---------------------------------------------------------------------------
module register_bank8 #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pc_incr,
    output logic [WIDTH-1:0] R0,
    output logic [WIDTH-1:0] R1,
    output logic [WIDTH-1:0] R2,
    output logic [WIDTH-1:0] R3,
    output logic [WIDTH-1:0] R4,
    output logic [WIDTH-1:0] R5,
    output logic [WIDTH-1:0] R6,
    output logic [WIDTH-1:0] R7,
    output logic [7:0]       written,
    output logic             pc_wrap
);

    localparam logic [WIDTH-1:0] pcStep = WIDTH'(1);

    logic [WIDTH-1:0] regFile [0:7];
    logic             writeToPc;
    logic             doIncr;

    // An explicit write to R7 takes priority over the auto-increment.
    assign writeToPc = wr_en && (wr_addr == 3'd7);
    assign doIncr    = pc_incr && !writeToPc;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 7; i++) begin
                regFile[i] <= '0;
            end
            regFile[7] <= PC_RESET;
            written    <= '0;
            pc_wrap    <= 1'b0;
        end else begin
            pc_wrap <= 1'b0;
            if (doIncr) begin
                regFile[7] <= regFile[7] + pcStep;
                // Wrap is judged on the value before the increment.
                pc_wrap    <= &regFile[7];
            end
            if (wr_en) begin
                regFile[wr_addr] <= wr_data;
                written[wr_addr] <= 1'b1;
            end
        end
    end

    assign R0 = regFile[0];
    assign R1 = regFile[1];
    assign R2 = regFile[2];
    assign R3 = regFile[3];
    assign R4 = regFile[4];
    assign R5 = regFile[5];
    assign R6 = regFile[6];
    assign R7 = regFile[7];

endmodule

// File: tb/tb_register_bank8.sv
module tb_register_bank8;

    logic        clock;
    logic        reset;
    logic        wrEn;
    logic [2:0]  wrAddr;
    logic [15:0] wrData;
    logic        pcIncr;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [7:0]  written;
    logic        pcWrap;

    logic [15:0] obsR [8];
    logic [15:0] expR [8];
    logic [7:0]  expWritten;
    logic        expWrap;

    logic [2:0]  muxSel;
    logic [15:0] muxOut;
    logic [15:0] expQ [$];

    int checks = 0;
    int errors = 0;

    register_bank8 #(.WIDTH(16), .PC_RESET(16'h0000)) dut (
        .Clock  (clock),
        .Reset  (reset),
        .wr_en  (wrEn),
        .wr_addr(wrAddr),
        .wr_data(wrData),
        .pc_incr(pcIncr),
        .R0     (r0),
        .R1     (r1),
        .R2     (r2),
        .R3     (r3),
        .R4     (r4),
        .R5     (r5),
        .R6     (r6),
        .R7     (r7),
        .written(written),
        .pc_wrap(pcWrap)
    );

    // ---------------- clock / reset block ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    always_comb begin
        obsR[0] = r0; obsR[1] = r1; obsR[2] = r2; obsR[3] = r3;
        obsR[4] = r4; obsR[5] = r5; obsR[6] = r6; obsR[7] = r7;
    end

    // Bench-side 8:1 bus mux driven by the bank outputs.
    always_comb begin
        case (muxSel)
            3'd0:    muxOut = r0;
            3'd1:    muxOut = r1;
            3'd2:    muxOut = r2;
            3'd3:    muxOut = r3;
            3'd4:    muxOut = r4;
            3'd5:    muxOut = r5;
            3'd6:    muxOut = r6;
            default: muxOut = r7;
        endcase
    end

    // Protocol check: address must be known whenever a write is requested.
    always @(negedge clock) begin
        if (wrEn === 1'b1) begin
            assert (!$isunknown(wrAddr))
            else $error("FAIL wr_addr_known observed=%b expected=known", wrAddr);
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string stepName);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("%s_R%0d", stepName, j), obsR[j], expR[j]);
        end
        check({stepName, "_written"}, {8'h00, written}, {8'h00, expWritten});
        check({stepName, "_pc_wrap"}, {15'h0000, pcWrap}, {15'h0000, expWrap});
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic we, input logic [2:0] addr,
                         input logic [15:0] data, input logic incr);
        @(negedge clock);
        reset  = rst;
        wrEn   = we;
        wrAddr = addr;
        wrData = data;
        pcIncr = incr;
    endtask

    task automatic step(input logic rst, input logic we, input logic [2:0] addr,
                        input logic [15:0] data, input logic incr);
        drive(rst, we, addr, data, incr);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset  = 1'b1;
        wrEn   = 1'b0;
        wrAddr = 3'd0;
        wrData = 16'h0000;
        pcIncr = 1'b0;
        muxSel = 3'd0;

        // 1. Reset held for two edges.
        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0);
        for (int j = 0; j < 8; j++) expR[j] = 16'h0000;
        expWritten = 8'h00;
        expWrap    = 1'b0;
        checkAll("reset");
        idle();
        checkAll("reset_release");

        // 2. Ri = i+1 on successive edges; only Ri changes each time.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'(i), 16'(i + 1), 1'b0);
            expR[i]       = 16'(i + 1);
            expWritten[i] = 1'b1;
            checkAll($sformatf("fill%0d", i));
        end
        check("fill_written_all", {8'h00, written}, 16'h00FF);

        // 6. Bank holds; the mux walks 1..8.
        idle();
        checkAll("hold");
        for (int s = 0; s < 8; s++) expQ.push_back(16'(s + 1));
        for (int s = 0; s < 8; s++) begin
            muxSel = 3'(s);
            #1;
            check($sformatf("mux_sel%0d", s), muxOut, expQ.pop_front());
        end

        // 3. Write to R7 and pc_incr together: write wins. No bypass before the edge.
        drive(1'b0, 1'b1, 3'd7, 16'h00AA, 1'b1);
        #1;
        check("no_bypass_R7", r7, 16'h0008);
        @(posedge clock);
        #1;
        expR[7] = 16'h00AA;
        checkAll("wr_vs_incr");

        // Write to another register alongside pc_incr: both land.
        step(1'b0, 1'b1, 3'd2, 16'h0055, 1'b1);
        expR[2] = 16'h0055;
        expR[7] = 16'h00AB;
        checkAll("wr_r2_and_incr");

        // 4. Wrap of the program counter.
        step(1'b0, 1'b1, 3'd7, 16'hFFFF, 1'b0);
        expR[7] = 16'hFFFF;
        checkAll("pc_all_ones");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
        expR[7] = 16'h0000;
        expWrap = 1'b1;
        checkAll("pc_wrap");
        step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
        expR[7] = 16'h0001;
        expWrap = 1'b0;
        checkAll("pc_after_wrap");
        idle();
        checkAll("pc_wrap_cleared");

        // 5. Reset dominates a simultaneous write.
        step(1'b1, 1'b1, 3'd3, 16'h1234, 1'b1);
        for (int j = 0; j < 8; j++) expR[j] = 16'h0000;
        expWritten = 8'h00;
        checkAll("reset_vs_write");
        step(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0);
        expR[3]       = 16'h1234;
        expWritten[3] = 1'b1;
        checkAll("write_after_reset");

        // pc_incr alone must not mark R7 as written.
        step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
        expR[7] = 16'h0001;
        checkAll("incr_not_written");

        // Back-to-back writes to one address: last wins, bit stays set.
        step(1'b0, 1'b1, 3'd3, 16'hAAAA, 1'b0);
        expR[3] = 16'hAAAA;
        checkAll("rewrite1");
        step(1'b0, 1'b1, 3'd3, 16'h5555, 1'b0);
        expR[3] = 16'h5555;
        checkAll("rewrite2");
        idle();
        checkAll("final_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
